// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared access-size and FSM encodings plus lane helpers for mem_stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_WORD = 2'd1,
        MEM_HALF = 2'd2,
        MEM_BYTE = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_RESP = 2'd2
    } mem_state_e;

    // Big-endian lanes: be[3] is byte offset 0 (bits 31:24).
    // WORD ignores the offset and HALF ignores offset bit 0, so misaligned
    // accesses fold onto the containing aligned unit.
    function automatic logic [3:0] byte_enables(input mem_size_e size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            MEM_WORD: be = 4'b1111;
            MEM_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            MEM_BYTE: be = 4'b1000 >> off;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated into every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] b);
        logic [31:0] d;
        d = b;
        case (size)
            MEM_HALF: d = {b[15:0], b[15:0]};
            MEM_BYTE: d = {4{b[7:0]}};
            default:  d = b;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_format.sv
// rtl/mem_load_format.sv - big-endian lane select and sign extension of a data-memory read word
module mem_load_format
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  mem_size_e   i_size,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane (offset 0 is the most significant byte) and sign-extend it.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;
        case (i_size)
            MEM_WORD: o_data = i_rdata;
            MEM_HALF: begin
                w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
                o_data = {{16{w_half[15]}}, w_half};
            end
            MEM_BYTE: begin
                case (i_off)
                    2'd0:    w_byte = i_rdata[31:24];
                    2'd1:    w_byte = i_rdata[23:16];
                    2'd2:    w_byte = i_rdata[15:8];
                    default: w_byte = i_rdata[7:0];
                endcase
                o_data = {{24{w_byte[7]}}, w_byte};
            end
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with req/ack data memory, stall, timeout and optional MEM_MISALIGN_TRAP_EN
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DADDR_W     = 32,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        EXMEM_pc_branched_i,
    input  logic [31:0]        EXMEM_alu_i,
    input  logic               EXMEM_alu_do_branch_i,
    input  logic [31:0]        EXMEM_b_i,
    input  logic [4:0]         EXMEM_reg_write_address_i,
    input  logic               EXMEM_ctrl_branch_i,
    input  logic [1:0]         EXMEM_ctrl_mem_read_i,
    input  logic [1:0]         EXMEM_ctrl_mem_write_i,
    input  logic               EXMEM_ctrl_reg_write_i,
    input  logic               EXMEM_ctrl_mem_to_reg_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [DADDR_W-1:0] dmem_addr_o,
    output logic [3:0]         dmem_be_o,
    output logic [31:0]        dmem_wdata_o,
    input  logic [31:0]        dmem_rdata_i,
    input  logic               dmem_ack_i,
    output logic               mem_stall_o,
    output logic               dmem_err_o,
    output logic               MEM_do_branch_o,
    output logic [31:0]        MEM_pc_branched_o,
    output logic [31:0]        MEMWB_read_data_o,
    output logic [31:0]        MEMWB_alu_o,
    output logic [4:0]         MEMWB_reg_write_address_o,
    output logic               MEMWB_ctrl_reg_write_o,
    output logic               MEMWB_ctrl_mem_to_reg_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    mem_state_e         r_state;
    mem_state_e         w_next;
    logic [DADDR_W-1:0] r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic               r_we;
    mem_size_e          r_lsize;
    logic [1:0]         r_off;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_buf;
    logic               r_trap;
    logic               r_err;

    mem_size_e          w_rd_size;
    mem_size_e          w_wr_size;
    mem_size_e          w_size;
    logic               w_is_store;
    logic               w_mem_op;
    logic [1:0]         w_off;
    logic               w_trap;
    logic               w_timeout;
    logic               w_latch;
    logic [31:0]        w_fmt;

    // A store takes priority when both read and write sizes are set.
    assign w_rd_size  = mem_size_e'(EXMEM_ctrl_mem_read_i);
    assign w_wr_size  = mem_size_e'(EXMEM_ctrl_mem_write_i);
    assign w_is_store = (w_wr_size != MEM_NONE);
    assign w_size     = w_is_store ? w_wr_size : w_rd_size;
    assign w_mem_op   = (w_size != MEM_NONE);
    assign w_off      = EXMEM_alu_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size == MEM_WORD) && (w_off != 2'b00)) ||
                        ((w_size == MEM_HALF) && w_off[0]);
    assign w_trap     = w_mem_op & w_misalign;
`else
    assign w_trap     = 1'b0;
`endif

    // ACK_TIMEOUT of zero disables the abort and waits for ack indefinitely.
    assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == CNT_LAST);

    assign MEM_do_branch_o   = EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;
    assign MEM_pc_branched_o = EXMEM_pc_branched_i;

    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign dmem_we_o    = dmem_req_o & r_we;
    assign dmem_be_o    = dmem_req_o ? r_be : 4'b0000;
    assign dmem_err_o   = r_err;

    mem_load_format u_load_format (
        .i_rdata (r_buf),
        .i_size  (r_lsize),
        .i_off   (r_off),
        .o_data  (w_fmt)
    );

    // State register; reset drops an in-flight request immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, stall, request and the MEM/WB latch strobe.
    always_comb begin
        w_next      = r_state;
        mem_stall_o = 1'b0;
        dmem_req_o  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_mem_op) begin
                    mem_stall_o = 1'b1;
                    w_next      = w_trap ? MS_RESP : MS_REQ;
                end else begin
                    w_latch = 1'b1;
                end
            end
            MS_REQ: begin
                mem_stall_o = 1'b1;
                dmem_req_o  = 1'b1;
                if (dmem_ack_i || w_timeout) begin
                    w_next = MS_RESP;
                end
            end
            MS_RESP: begin
                w_latch = 1'b1;
                w_next  = MS_IDLE;
            end
            default: w_next = MS_IDLE;
        endcase
    end

    // Access setup in IDLE, then ack capture or timeout abort while in REQ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0000_0000;
            r_we    <= 1'b0;
            r_lsize <= MEM_NONE;
            r_off   <= 2'b00;
            r_cnt   <= '0;
            r_buf   <= 32'h0000_0000;
            r_trap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                MS_IDLE: begin
                    if (w_mem_op) begin
                        r_addr  <= {EXMEM_alu_i[DADDR_W-1:2], 2'b00};
                        r_be    <= byte_enables(w_size, w_off);
                        r_wdata <= store_lanes(w_size, EXMEM_b_i);
                        r_we    <= w_is_store;
                        r_lsize <= w_is_store ? MEM_NONE : w_size;
                        r_off   <= w_off;
                        r_cnt   <= '0;
                        r_buf   <= 32'h0000_0000;
                        r_trap  <= w_trap;
                        r_err   <= w_trap;
                    end
                end
                MS_REQ: begin
                    if (dmem_ack_i) begin
                        r_buf <= dmem_rdata_i;
                    end else if (w_timeout) begin
                        r_buf <= 32'h0000_0000;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM/WB register: latch on a completed instruction, otherwise insert a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            MEMWB_read_data_o         <= 32'h0000_0000;
            MEMWB_alu_o               <= 32'h0000_0000;
            MEMWB_reg_write_address_o <= 5'd0;
            MEMWB_ctrl_reg_write_o    <= 1'b0;
            MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
        end else if (w_latch) begin
            MEMWB_read_data_o         <= (r_state == MS_RESP) ? w_fmt : 32'h0000_0000;
            MEMWB_alu_o               <= EXMEM_alu_i;
            MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
            MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i & ~((r_state == MS_RESP) & r_trap);
            MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i;
        end else begin
            MEMWB_ctrl_reg_write_o    <= 1'b0;
            MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
        end
    end

endmodule
